// File: rtl/sfp_uart_tx.sv
// Asynchronous byte-framing transmitter feeding the SFP tx pin: start, LSB-first data,
// optional parity, one stop bit; the line is held low whenever the link qualifier is down.
//
// state  | meaning
// IDLE   | waiting for a byte; line idles high only while the link is up
// START  | start bit (line low)
// DATA   | data bits, LSB first
// PARITY | parity bit (only when PARITY != 0)
// STOP   | stop bit (line high)
module sfp_uart_tx #(
   parameter int CLKS_PER_BIT = 100,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_enable,
   input  logic [DATA_BITS-1:0] i_data,
   input  logic                 i_valid,
   output logic                 o_ready,
   output logic                 o_tx,
   output logic                 o_busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(DATA_BITS + 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PAR    = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
   localparam logic          ODD      = (PARITY == 2);

   logic [2:0]           r_state;
   logic [CW-1:0]        r_cnt;
   logic [IW-1:0]        r_idx;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par;
   logic                 r_tx;

   logic w_hs;
   logic w_last;

   assign o_ready = (r_state == IDLE) && i_enable;
   assign w_hs    = o_ready && i_valid;
   assign w_last  = (r_cnt == CNT_LAST);
   assign o_busy  = (r_state != IDLE);
   assign o_tx    = r_tx;

   // r_tx is loaded with the value of the state being entered, so the line and the
   // state register always change on the same edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_par   <= 1'b0;
         r_tx    <= 1'b0;
      end else if ((r_state != IDLE) && !i_enable) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_par   <= 1'b0;
         r_tx    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_hs) begin
                  r_shift <= i_data;
                  r_par   <= (^i_data) ^ ODD;
                  r_cnt   <= '0;
                  r_idx   <= '0;
                  r_state <= START;
                  r_tx    <= 1'b0;
               end else begin
                  r_tx    <= i_enable;
               end
            end
            START: begin
               if (w_last) begin
                  r_cnt   <= '0;
                  r_state <= DATA;
                  r_tx    <= r_shift[0];
               end else begin
                  r_cnt   <= r_cnt + 1'b1;
               end
            end
            DATA: begin
               if (w_last) begin
                  r_cnt   <= '0;
                  r_shift <= r_shift >> 1;
                  if (r_idx == IDX_LAST) begin
                     r_idx <= '0;
                     if (PARITY != 0) begin
                        r_state <= PAR;
                        r_tx    <= r_par;
                     end else begin
                        r_state <= STOP;
                        r_tx    <= 1'b1;
                     end
                  end else begin
                     r_idx <= r_idx + 1'b1;
                     r_tx  <= r_shift[1];
                  end
               end else begin
                  r_cnt   <= r_cnt + 1'b1;
               end
            end
            PAR: begin
               if (w_last) begin
                  r_cnt   <= '0;
                  r_state <= STOP;
                  r_tx    <= 1'b1;
               end else begin
                  r_cnt   <= r_cnt + 1'b1;
               end
            end
            STOP: begin
               if (w_last) begin
                  r_cnt   <= '0;
                  r_state <= IDLE;
                  r_tx    <= 1'b1;
               end else begin
                  r_cnt   <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
               r_idx   <= '0;
               r_tx    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sfp_uart_tx.sv
// Bench for sfp_uart_tx: three instances (no parity, even, odd) checked against a
// bit-list frame model built from the framing rules.
module tb_sfp_uart_tx;

   localparam int CPB = 100;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [7:0] din;
   logic [2:0] vld;
   logic [2:0] w_rdy, w_tx, w_busy;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   sfp_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0)) u_p0 (
      .clk(clk), .rst_n(rst_n), .i_enable(en), .i_data(din), .i_valid(vld[0]),
      .o_ready(w_rdy[0]), .o_tx(w_tx[0]), .o_busy(w_busy[0]));
   sfp_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1)) u_p1 (
      .clk(clk), .rst_n(rst_n), .i_enable(en), .i_data(din), .i_valid(vld[1]),
      .o_ready(w_rdy[1]), .o_tx(w_tx[1]), .o_busy(w_busy[1]));
   sfp_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2)) u_p2 (
      .clk(clk), .rst_n(rst_n), .i_enable(en), .i_data(din), .i_valid(vld[2]),
      .o_ready(w_rdy[2]), .o_tx(w_tx[2]), .o_busy(w_busy[2]));

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected line levels of one frame, one entry per bit period.
   function automatic void build_frame(input logic [7:0] d, input int par, output bit q[$]);
      int ones;
      q = {};
      q.push_back(1'b0);
      ones = 0;
      for (int i = 0; i < 8; i++) begin
         q.push_back(d[i]);
         ones += d[i];
      end
      if (par != 0) q.push_back(bit'((ones % 2) ^ (par == 2 ? 1 : 0)));
      q.push_back(1'b1);
   endfunction

   // Entered at the sample point just after the handshake edge; returns at the
   // sample point of the first cycle after the frame.
   task automatic check_frame(input int idx, input logic [7:0] d, input bit disturb);
      bit q[$];
      int busy_cnt, match;
      build_frame(d, idx, q);
      busy_cnt = 0;
      for (int b = 0; b < q.size(); b++) begin
         match = 0;
         for (int c = 0; c < CPB; c++) begin
            if (w_tx[idx] == q[b]) match++;
            if (w_busy[idx]) busy_cnt++;
            if (disturb) begin
               din = 8'($urandom);
               vld[idx] = (b == q.size() - 1) && (c == CPB / 2);
            end
            step();
         end
         chk($sformatf("dut%0d_bit%0d", idx, b), match, CPB);
      end
      vld[idx] = vld[idx] & ~disturb;
      chk($sformatf("dut%0d_busy_len", idx), busy_cnt, q.size() * CPB);
      chk("post_busy", int'(w_busy[idx]), 0);
      chk("post_tx", int'(w_tx[idx]), 1);
      chk("post_ready", int'(w_rdy[idx]), 1);
   endtask

   task automatic handshake(input int idx, input logic [7:0] d);
      din = d;
      vld[idx] = 1'b1;
      chk("ready_pre", int'(w_rdy[idx]), 1);
      step();
      vld[idx] = 1'b0;
      chk("start_tx", int'(w_tx[idx]), 0);
      chk("start_busy", int'(w_busy[idx]), 1);
   endtask

   task automatic idle_watch(input int idx, input int n);
      int busy_cnt;
      busy_cnt = 0;
      for (int i = 0; i < n; i++) begin
         if (w_busy[idx] || !w_tx[idx]) busy_cnt++;
         step();
      end
      chk("idle_quiet", busy_cnt, 0);
   endtask

   initial begin
      logic [7:0] rb;
      rst_n = 1'b0; en = 1'b0; din = 8'h00; vld = 3'b000;
      step(); step();
      rst_n = 1'b1;
      step();
      chk("rst_tx", int'(w_tx), 0);
      chk("rst_busy", int'(w_busy), 0);
      chk("rst_ready_en0", int'(w_rdy), 0);
      en = 1'b1;
      #1;
      chk("ready_comb", int'(w_rdy), 7);
      step();
      chk("tx_after_en", int'(w_tx), 7);

      // Directed frames
      handshake(0, 8'hA5); check_frame(0, 8'hA5, 1'b0);
      handshake(1, 8'h07); check_frame(1, 8'h07, 1'b0);
      handshake(2, 8'h07); check_frame(2, 8'h07, 1'b0);

      // Back-to-back with valid held: 0x00 then 0xFF
      din = 8'h00; vld[0] = 1'b1;
      step();
      din = 8'hFF;
      chk("b2b_start1", int'(w_tx[0]), 0);
      check_frame(0, 8'h00, 1'b0);
      step();
      vld[0] = 1'b0;
      chk("b2b_start2_tx", int'(w_tx[0]), 0);
      chk("b2b_start2_busy", int'(w_busy[0]), 1);
      check_frame(0, 8'hFF, 1'b0);

      // Abort during data bit 3
      handshake(0, 8'h55);
      for (int i = 0; i < 4 * CPB + 40; i++) step();
      en = 1'b0;
      step();
      chk("abort_tx", int'(w_tx[0]), 0);
      chk("abort_busy", int'(w_busy[0]), 0);
      chk("abort_ready", int'(w_rdy[0]), 0);
      step();
      en = 1'b1;
      step();
      chk("reen_tx", int'(w_tx[0]), 1);
      handshake(0, 8'h55); check_frame(0, 8'h55, 1'b0);

      // Reset mid stop bit
      handshake(1, 8'h3C);
      for (int i = 0; i < 10 * CPB + 50; i++) step();
      chk("pre_rst_in_stop", int'(w_tx[1]), 1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("midrst_tx", int'(w_tx[1]), 0);
      chk("midrst_busy", int'(w_busy[1]), 0);
      step();
      idle_watch(1, 3 * CPB);

      // Data changes and valid pulse in STOP while busy
      handshake(0, 8'hC3); check_frame(0, 8'hC3, 1'b1);
      idle_watch(0, 2 * CPB);
      handshake(2, 8'h9A); check_frame(2, 8'h9A, 1'b1);
      idle_watch(2, 2 * CPB);

      // Random bytes on every variant
      for (int k = 0; k < 4; k++) begin
         for (int idx = 0; idx < 3; idx++) begin
            rb = 8'($urandom);
            handshake(idx, rb);
            check_frame(idx, rb, 1'b0);
            for (int g = $urandom_range(0, 3); g > 0; g--) step();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
